// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU control codes, divider FSM states, word width.
// Used by the ALU decoder and the HI/LO multiply/divide unit.
package mips_pkg;

    localparam int WORD = 32;

    typedef enum logic [4:0] {
        ALU_NOP   = 5'h00,
        ALU_MULT  = 5'h10,
        ALU_MULTU = 5'h11,
        ALU_DIV   = 5'h12,
        ALU_DIVU  = 5'h13,
        ALU_MTHI  = 5'h14,
        ALU_MTLO  = 5'h15,
        ALU_MFHI  = 5'h16,
        ALU_MFLO  = 5'h17
    } alu_control_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between the execute datapath and the HI/LO unit.
// master = datapath side, slave = hilo_muldiv_unit.
interface hilo_muldiv_unit_if;
    import mips_pkg::*;

    logic            start;
    logic [4:0]      alu_control;
    logic            LO_write_enable;
    logic            HI_write_enable;
    logic [WORD-1:0] op_a;
    logic [WORD-1:0] op_b;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [WORD-1:0] hi;
    logic [WORD-1:0] lo;
    logic [WORD-1:0] mf_data;

    modport master (
        output start, alu_control, LO_write_enable, HI_write_enable,
        output op_a, op_b,
        input  busy, done, div_by_zero, hi, lo, mf_data
    );

    modport slave (
        input  start, alu_control, LO_write_enable, HI_write_enable,
        input  op_a, op_b,
        output busy, done, div_by_zero, hi, lo, mf_data
    );

endinterface

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// fin is high for the single FIX cycle in which quotient/remainder are final.
import mips_pkg::*;

module serial_divider #(
    parameter int STEPS = WORD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [WORD-1:0] dividend,
    input  logic [WORD-1:0] divisor,
    output logic            busy,
    output logic            fin,
    output logic [WORD-1:0] quotient,
    output logic [WORD-1:0] remainder
);

    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    div_state_t      state;
    logic [CW-1:0]   cnt;
    logic [WORD-1:0] rem;
    logic [WORD-1:0] quo;
    logic [WORD-1:0] dvs;
    logic [WORD:0]   shifted;
    logic [WORD:0]   trial;
    logic            ge;

    // One restoring step: shift in the next dividend bit, try to subtract.
    always_comb begin
        shifted = {rem, quo[WORD-1]};
        trial   = shifted - {1'b0, dvs};
        ge      = ~trial[WORD];
    end

    // Divider FSM with registered busy/fin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            busy  <= 1'b0;
            fin   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        rem   <= '0;
                        quo   <= dividend;
                        dvs   <= divisor;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    rem <= ge ? trial[WORD-1:0] : shifted[WORD-1:0];
                    quo <= {quo[WORD-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        fin   <= 1'b1;
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    fin   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner: single-cycle MULT/MULTU, iterative DIV/DIVU, MTHI/MTLO/MFHI/MFLO.
// Optional macro HILO_BYPASS_EN forwards an accepted MTHI/MTLO operand to hi/lo/mf_data in the same cycle.
import mips_pkg::*;

module hilo_muldiv_unit #(
    parameter int DIV_STEPS = WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    hilo_muldiv_unit_if.slave bus
);

    alu_control_t      op;
    logic              busy;
    logic              fin;
    logic              accept;
    logic              is_div;
    logic              div_go;
    logic              a_neg;
    logic              b_neg;
    logic              q_neg;
    logic              r_neg;
    logic              done_q;
    logic              dbz_q;
    logic              byp_hi;
    logic              byp_lo;
    logic [WORD-1:0]   hi_q;
    logic [WORD-1:0]   lo_q;
    logic [WORD-1:0]   a_mag;
    logic [WORD-1:0]   b_mag;
    logic [WORD-1:0]   quo;
    logic [WORD-1:0]   rem;
    logic [WORD-1:0]   hi_out;
    logic [WORD-1:0]   lo_out;
    logic [2*WORD-1:0] ext_a;
    logic [2*WORD-1:0] ext_b;
    logic [2*WORD-1:0] prod;

    assign op     = alu_control_t'(bus.alu_control);
    assign accept = bus.start & ~busy
                  & (bus.LO_write_enable | bus.HI_write_enable);
    assign is_div = (op == ALU_DIV) || (op == ALU_DIVU);
    assign div_go = accept & is_div & (bus.op_b != '0);

    // Operand magnitudes for the unsigned core; raw values for DIVU.
    assign a_neg = (op == ALU_DIV) & bus.op_a[WORD-1];
    assign b_neg = (op == ALU_DIV) & bus.op_b[WORD-1];
    assign a_mag = a_neg ? -bus.op_a : bus.op_a;
    assign b_mag = b_neg ? -bus.op_b : bus.op_b;

    // Low 64 bits of the extended product are the exact 32x32 result.
    assign ext_a = {{WORD{(op == ALU_MULT) & bus.op_a[WORD-1]}}, bus.op_a};
    assign ext_b = {{WORD{(op == ALU_MULT) & bus.op_b[WORD-1]}}, bus.op_b};
    assign prod  = ext_a * ext_b;

    serial_divider #(
        .STEPS(DIV_STEPS)
    ) u_div (
        .clk       (clk),
        .rst_n     (reset_n),
        .start     (div_go),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (busy),
        .fin       (fin),
        .quotient  (quo),
        .remainder (rem)
    );

    // HI/LO registers, result signs and completion pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (fin) begin
                lo_q   <= q_neg ? -quo : quo;
                hi_q   <= r_neg ? -rem : rem;
                done_q <= 1'b1;
            end else if (accept) begin
                case (op)
                    ALU_MTHI: if (bus.HI_write_enable) hi_q <= bus.op_a;
                    ALU_MTLO: if (bus.LO_write_enable) lo_q <= bus.op_a;
                    ALU_MULT, ALU_MULTU: begin
                        hi_q   <= prod[2*WORD-1:WORD];
                        lo_q   <= prod[WORD-1:0];
                        done_q <= 1'b1;
                    end
                    ALU_DIV, ALU_DIVU: begin
                        if (bus.op_b == '0) begin
                            done_q <= 1'b1;
                            dbz_q  <= 1'b1;
                        end else begin
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef HILO_BYPASS_EN
    assign byp_hi = bus.start & ~busy & bus.HI_write_enable
                  & (op == ALU_MTHI);
    assign byp_lo = bus.start & ~busy & bus.LO_write_enable
                  & (op == ALU_MTLO);
`else
    assign byp_hi = 1'b0;
    assign byp_lo = 1'b0;
`endif

    assign hi_out = byp_hi ? bus.op_a : hi_q;
    assign lo_out = byp_lo ? bus.op_a : lo_q;

    // Move-from read port.
    always_comb begin
        bus.mf_data = '0;
        if (op == ALU_MFHI) bus.mf_data = hi_out;
        else if (op == ALU_MFLO) bus.mf_data = lo_out;
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_out;
    assign bus.lo          = lo_out;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: arithmetic reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_hilo_muldiv_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if bus();

    hilo_muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic
    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x, y;
        if (s) begin
            x = $signed(a);
            y = $signed(b);
            return x * y;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Returns {remainder, quotient}
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x, y, q, r;
        if (s) begin
            x = $signed(a);
            y = $signed(b);
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural model: divide result appears 33 edges after acceptance
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_cnt;
    logic        m_done, m_dbz;
    logic [63:0] tmp;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end else if (bus.start &&
                         (bus.HI_write_enable || bus.LO_write_enable)) begin
                case (bus.alu_control)
                    ALU_MTHI: if (bus.HI_write_enable) m_hi <= bus.op_a;
                    ALU_MTLO: if (bus.LO_write_enable) m_lo <= bus.op_a;
                    ALU_MULT, ALU_MULTU: begin
                        tmp = ref_mul(bus.alu_control == ALU_MULT,
                                      bus.op_a, bus.op_b);
                        m_hi   <= tmp[63:32];
                        m_lo   <= tmp[31:0];
                        m_done <= 1'b1;
                    end
                    ALU_DIV, ALU_DIVU: begin
                        if (bus.op_b == 0) begin
                            m_done <= 1'b1;
                            m_dbz  <= 1'b1;
                        end else begin
                            tmp = ref_div(bus.alu_control == ALU_DIV,
                                          bus.op_a, bus.op_b);
                            p_hi  <= tmp[63:32];
                            p_lo  <= tmp[31:0];
                            m_cnt <= 33;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [31:0] d_hi, d_lo, d_mf;
    logic        bp_hi, bp_lo;
`ifdef HILO_BYPASS_EN
    assign bp_hi = bus.start && m_cnt == 0 && bus.HI_write_enable
                 && bus.alu_control == ALU_MTHI;
    assign bp_lo = bus.start && m_cnt == 0 && bus.LO_write_enable
                 && bus.alu_control == ALU_MTLO;
`else
    assign bp_hi = 1'b0;
    assign bp_lo = 1'b0;
`endif
    assign d_hi = bp_hi ? bus.op_a : m_hi;
    assign d_lo = bp_lo ? bus.op_a : m_lo;
    assign d_mf = (bus.alu_control == ALU_MFHI) ? d_hi :
                  (bus.alu_control == ALU_MFLO) ? d_lo : 32'h0;

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'b0, bus.busy}, {31'b0, m_cnt != 0});
            chk("done", {31'b0, bus.done}, {31'b0, m_done});
            chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, m_dbz});
            chk("hi", bus.hi, d_hi);
            chk("lo", bus.lo, d_lo);
            chk("mf_data", bus.mf_data, d_mf);
        end
    end

    task automatic idle_inputs();
        bus.start           = 1'b0;
        bus.alu_control     = ALU_NOP;
        bus.HI_write_enable = 1'b0;
        bus.LO_write_enable = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit hwe, input bit lwe);
        bus.start           = 1'b1;
        bus.alu_control     = op;
        bus.op_a            = a;
        bus.op_b            = b;
        bus.HI_write_enable = hwe;
        bus.LO_write_enable = lwe;
    endtask

    // One-cycle issue; returns just after the negedge following acceptance
    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit hwe, input bit lwe);
        @(negedge clk);
        #1;
        drive(op, a, b, hwe, lwe);
        @(negedge clk);
        #1;
        idle_inputs();
    endtask

    // Counts busy-high samples; returns at the negedge where busy is low
    task automatic wait_div(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("div_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int n;
    int dcount;

    initial begin
        idle_inputs();
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_done", {31'b0, bus.done}, 32'h0);
        #1 reset_n = 1'b1;
        cmp_en = 1'b1;

        issue(ALU_MULT, 32'hFFFFFFFE, 32'd3, 1, 1);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFFA);
        chk("mult_done", {31'b0, bus.done}, 32'h1);

        issue(ALU_MULTU, 32'hFFFFFFFE, 32'd3, 1, 1);
        chk("multu_hi", bus.hi, 32'h00000002);
        chk("multu_lo", bus.lo, 32'hFFFFFFFA);

        issue(ALU_DIV, 32'hFFFFFFF9, 32'd2, 1, 1);
        wait_div(n);
        chk("div_busy_cycles", 32'(n), 32'd33);
        chk("div_done", {31'b0, bus.done}, 32'h1);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);

        issue(ALU_DIVU, 32'hFFFFFFFF, 32'h10, 1, 1);
        wait_div(n);
        chk("divu_lo", bus.lo, 32'h0FFFFFFF);
        chk("divu_hi", bus.hi, 32'h0000000F);

        issue(ALU_DIV, 32'd7, 32'hFFFFFFFE, 1, 1);
        wait_div(n);
        chk("div_pos_neg_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_pos_neg_hi", bus.hi, 32'h00000001);

        issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 1);
        wait_div(n);
        chk("div_ovf_lo", bus.lo, 32'h80000000);
        chk("div_ovf_hi", bus.hi, 32'h00000000);

        issue(ALU_MTHI, 32'h11, 32'h0, 1, 0);
        issue(ALU_MTLO, 32'h22, 32'h0, 0, 1);
        issue(ALU_DIV, 32'h1234, 32'h0, 1, 1);
        chk("dbz_pulse", {31'b0, bus.div_by_zero}, 32'h1);
        chk("dbz_done", {31'b0, bus.done}, 32'h1);
        chk("dbz_busy", {31'b0, bus.busy}, 32'h0);
        chk("dbz_hi", bus.hi, 32'h11);
        chk("dbz_lo", bus.lo, 32'h22);

        @(negedge clk);
        #1;
        drive(ALU_MTHI, 32'hDEADBEEF, 32'h0, 1, 0);
        #1;
`ifdef HILO_BYPASS_EN
        chk("mthi_bypass", bus.hi, 32'hDEADBEEF);
`else
        chk("mthi_registered", bus.hi, 32'h00000011);
`endif
        @(negedge clk);
        #1;
        idle_inputs();
        bus.alu_control = ALU_MFHI;
        #1;
        chk("mfhi", bus.mf_data, 32'hDEADBEEF);
        bus.alu_control = ALU_MFLO;
        #1;
        chk("mflo", bus.mf_data, 32'h00000022);
        bus.alu_control = ALU_NOP;

        issue(ALU_DIV, 32'd100, 32'd7, 1, 1);
        repeat (9) @(negedge clk);
        #1;
        drive(ALU_MTLO, 32'h5, 32'h0, 0, 1);
        @(negedge clk);
        #1;
        idle_inputs();
        wait_div(n);
        chk("busy_ign_lo", bus.lo, 32'd14);
        chk("busy_ign_hi", bus.hi, 32'd2);

        issue(ALU_DIVU, 32'd1000, 32'd3, 1, 1);
        repeat (11) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        chk("abort_busy", {31'b0, bus.busy}, 32'h0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);

        issue(ALU_MULT, 32'd5, 32'd6, 1, 1);
        chk("post_rst_mult_lo", bus.lo, 32'd30);
        chk("post_rst_mult_hi", bus.hi, 32'd0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
